// File: rtl/inv_ksa_pkg.sv
// Shared definitions for the PRESENT-80 inverse key-schedule generator:
// sizes, S-box tables, lookup helpers and the controller state encoding.
package inv_ksa_pkg;

    localparam int KEY_SIZE   = 80;
    localparam int NUM_ROUNDS = 31;
    localparam int RK_WIDTH   = 64;
    localparam int IDX_WIDTH  = 5;

    // Nibble i of each table lives at bits [4*i+3 : 4*i].
    localparam logic [63:0] SBOX_TABLE     = 64'h2174_8FE3_DA09_B65C;
    localparam logic [63:0] INV_SBOX_TABLE = 64'hA970_364B_D21C_8FE5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_EMIT = 2'd2
    } ksa_state_e;

    function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
        return SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        return INV_SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/SBox.sv
// PRESENT 4-bit forward S-box (combinational).
module SBox
    import inv_ksa_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [3:0] nibble_o
);

    // Table lookup through the shared helper.
    always_comb begin
        nibble_o = sbox_fwd(nibble_i);
    end

endmodule

// File: rtl/inv_sbox.sv
// PRESENT 4-bit inverse S-box (combinational), used to undo a key-update step.
module inv_sbox
    import inv_ksa_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [3:0] nibble_o
);

    // Table lookup through the shared helper.
    always_comb begin
        nibble_o = sbox_inv(nibble_i);
    end

endmodule

// File: rtl/inv_ksa.sv
// PRESENT-80 inverse key schedule: runs the key register forward to the last
// round key, then walks it back one step per handshake, emitting K_32 .. K_1.
module inv_ksa #(
    parameter int KEY_SIZE   = inv_ksa_pkg::KEY_SIZE,
    parameter int NUM_ROUNDS = inv_ksa_pkg::NUM_ROUNDS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_SIZE-1:0] key,
    output logic                busy,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [63:0]         rk,
    output logic [4:0]          rk_idx,
    output logic                rk_last
);

    import inv_ksa_pkg::*;

    localparam logic [4:0] LAST_IDX = 5'(NUM_ROUNDS);

    ksa_state_e          fsm_q, fsm_d;
    logic [KEY_SIZE-1:0] state_q, state_d;
    logic [4:0]          ctr_q, ctr_d;
    logic [4:0]          rk_idx_q, rk_idx_d;
    logic [63:0]         rk_q, rk_d;
    logic                rk_valid_q, rk_valid_d;
    logic                rk_last_q, rk_last_d;
    logic                busy_q, busy_d;

    logic [3:0]          fwd_nib_s;
    logic [3:0]          inv_nib_s;
    logic [KEY_SIZE-1:0] fwd_step_s;
    logic [KEY_SIZE-1:0] inv_tmp_s;
    logic [KEY_SIZE-1:0] inv_step_s;

    // After the left-rotate by 61, the top nibble comes from state bits [18:15].
    SBox u_sbox (
        .nibble_i (state_q[18:15]),
        .nibble_o (fwd_nib_s)
    );

    inv_sbox u_inv_sbox (
        .nibble_i (state_q[KEY_SIZE-1 -: 4]),
        .nibble_o (inv_nib_s)
    );

    // Forward key-update: rotate left 61, S-box the top nibble, mix in ctr.
    always_comb begin
        fwd_step_s                 = {state_q[18:0], state_q[KEY_SIZE-1:19]};
        fwd_step_s[KEY_SIZE-1 -: 4] = fwd_nib_s;
        fwd_step_s[19:15]          = fwd_step_s[19:15] ^ ctr_q;
    end

    // Inverse key-update: undo the counter mix and S-box, then rotate right 61.
    always_comb begin
        inv_tmp_s                  = state_q;
        inv_tmp_s[19:15]           = inv_tmp_s[19:15] ^ rk_idx_q;
        inv_tmp_s[KEY_SIZE-1 -: 4] = inv_nib_s;
        inv_step_s                 = {inv_tmp_s[KEY_SIZE-20:0], inv_tmp_s[KEY_SIZE-1:KEY_SIZE-19]};
    end

    // Controller next-state and datapath selection.
    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        ctr_d    = ctr_q;
        rk_idx_d = rk_idx_q;
        case (fsm_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = key;
                    ctr_d    = 5'd1;
                    rk_idx_d = 5'd0;
                    fsm_d    = ST_FWD;
                end else begin
                    fsm_d    = ST_IDLE;
                end
            end
            ST_FWD: begin
                state_d = fwd_step_s;
                ctr_d   = ctr_q + 5'd1;
                if (ctr_q == LAST_IDX) begin
                    rk_idx_d = LAST_IDX;
                    fsm_d    = ST_EMIT;
                end else begin
                    fsm_d    = ST_FWD;
                end
            end
            ST_EMIT: begin
                if (rk_valid_q && rk_ready) begin
                    if (rk_idx_q == 5'd0) begin
                        // Leave nothing behind so IDLE outputs read as zero.
                        state_d  = '0;
                        ctr_d    = 5'd0;
                        rk_idx_d = 5'd0;
                        fsm_d    = ST_IDLE;
                    end else begin
                        state_d  = inv_step_s;
                        rk_idx_d = rk_idx_q - 5'd1;
                        fsm_d    = ST_EMIT;
                    end
                end else begin
                    fsm_d = ST_EMIT;
                end
            end
            default: begin
                state_d  = '0;
                ctr_d    = 5'd0;
                rk_idx_d = 5'd0;
                fsm_d    = ST_IDLE;
            end
        endcase
    end

    // Output values for the next cycle, derived from the next controller state.
    always_comb begin
        rk_valid_d = (fsm_d == ST_EMIT);
        rk_last_d  = (fsm_d == ST_EMIT) && (rk_idx_d == 5'd0);
        busy_d     = (fsm_d != ST_IDLE);
        rk_d       = (fsm_d == ST_EMIT) ? state_d[KEY_SIZE-1 -: 64] : 64'h0;
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q      <= ST_IDLE;
            state_q    <= '0;
            ctr_q      <= 5'd0;
            rk_idx_q   <= 5'd0;
            rk_q       <= 64'h0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            state_q    <= state_d;
            ctr_q      <= ctr_d;
            rk_idx_q   <= rk_idx_d;
            rk_q       <= rk_d;
            rk_valid_q <= rk_valid_d;
            rk_last_q  <= rk_last_d;
            busy_q     <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign rk_valid = rk_valid_q;
    assign rk       = rk_q;
    assign rk_idx   = rk_idx_q;
    assign rk_last  = rk_last_q;

endmodule

// File: tb/tb_inv_ksa.sv
// Randomized self-checking bench for inv_ksa against a plain forward-schedule model.
module tb_inv_ksa;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [79:0] key;
    logic        busy;
    logic        rk_valid;
    logic        rk_ready;
    logic [63:0] rk;
    logic [4:0]  rk_idx;
    logic        rk_last;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] obs_rk   [32];
    logic        obs_last [32];

    localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    always #5 clk = ~clk;

    inv_ksa dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key      (key),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk       (rk),
        .rk_idx   (rk_idx),
        .rk_last  (rk_last)
    );

    // Key register after n forward updates of the PRESENT-80 schedule (K_{n+1}).
    function automatic logic [79:0] ref_key_state(input logic [79:0] k, input int n);
        logic [79:0] s;
        s = k;
        for (int i = 1; i <= n; i++) begin
            s = (s << 61) | (s >> 19);
            s[79:76] = SB[s[79:76]];
            s = s ^ ({75'd0, 5'(i)} << 15);
        end
        return s;
    endfunction

    function automatic logic [79:0] rand_key();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[79:0];
    endfunction

    task automatic check_idle_outputs(input string name);
        n_tests++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || rk !== 64'h0 || rk_idx !== 5'd0 || rk_last !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: valid=%b busy=%b rk=%h idx=%0d last=%b, expected all zero",
                     name, rk_valid, busy, rk, rk_idx, rk_last);
        end
    endtask

    task automatic do_run(input logic [79:0] k, input bit rand_ready, input bit noise);
        logic [63:0] exp_rk [32];
        logic [79:0] t;
        int edges;
        int hs;
        int idx;
        int guard;
        bit rdy;
        for (int j = 0; j < 32; j++) begin
            t = ref_key_state(k, j);
            exp_rk[j] = t[79:16];
        end
        @(negedge clk);
        key = k; start = 1'b1; rk_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: busy=%b, expected 1", busy);
        end
        while (rk_valid !== 1'b1 && edges < 100) begin
            if (noise) begin
                key = rand_key();
                start = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            edges++;
        end
        n_tests++;
        if (edges != 32) begin
            n_fail++;
            $display("FAIL latency: rk_valid after %0d edges, expected 32", edges);
        end
        hs = 0; idx = 31; guard = 0;
        while (hs < 32 && guard < 3000) begin
            n_tests++;
            if (rk_valid !== 1'b1 || rk_idx !== 5'(idx) || rk !== exp_rk[idx] ||
                rk_last !== ((idx == 0) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL handshake: valid=%b idx=%0d rk=%h last=%b, expected valid=1 idx=%0d rk=%h last=%b",
                         rk_valid, rk_idx, rk, rk_last, idx, exp_rk[idx], (idx == 0));
            end
            obs_rk[idx] = rk;
            obs_last[idx] = rk_last;
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            rk_ready = rdy;
            if (noise) begin
                key = rand_key();
                start = (rdy && idx == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            if (rdy) begin
                hs++;
                idx--;
            end
            @(negedge clk);
            guard++;
        end
        rk_ready = 1'b0;
        start = 1'b0;
        n_tests++;
        if (hs != 32) begin
            n_fail++;
            $display("FAIL handshake_count: got %0d, expected 32", hs);
        end
        check_idle_outputs("idle_after_run");
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; key = 80'h0; rk_ready = 1'b0;
        #3;
        check_idle_outputs("reset_state");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("after_reset_release");
    endtask

    task automatic test_zero_key();
        do_run(80'h0, 1'b0, 1'b0);
        n_tests++;
        if (obs_rk[1] !== 64'hC000_0000_0000_0000) begin
            n_fail++;
            $display("FAIL zero_key_idx1: rk=%h, expected c000000000000000", obs_rk[1]);
        end
        n_tests++;
        if (obs_rk[0] !== 64'h0 || obs_last[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_key_idx0: rk=%h last=%b, expected 0 last=1", obs_rk[0], obs_last[0]);
        end
    endtask

    task automatic test_random_keys();
        logic [79:0] k;
        for (int r = 0; r < 4; r++) begin
            k = rand_key();
            do_run(k, 1'b0, 1'b0);
            n_tests++;
            if (obs_rk[0] !== k[79:16]) begin
                n_fail++;
                $display("FAIL final_key: rk=%h, expected %h", obs_rk[0], k[79:16]);
            end
        end
    endtask

    task automatic test_stall();
        for (int r = 0; r < 2; r++) begin
            do_run(rand_key(), 1'b1, 1'b0);
        end
    endtask

    task automatic watch_no_valid(input string name);
        bit seen;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (rk_valid !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL %s: rk_valid=1 seen after abort, expected 0", name);
        end
    endtask

    task automatic test_reset_abort();
        int guard;
        @(negedge clk);
        key = rand_key(); start = 1'b1; rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_idle_outputs("reset_in_fwd");
        @(negedge clk);
        rst = 1'b1;
        watch_no_valid("no_valid_after_fwd_abort");

        key = rand_key(); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(rk_valid === 1'b1 && rk_idx === 5'd17) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_tests++;
        if (guard >= 200) begin
            n_fail++;
            $display("FAIL reach_idx17: rk_idx=%0d after %0d cycles, expected 17", rk_idx, guard);
        end
        #2 rst = 1'b0;
        #1 check_idle_outputs("reset_in_emit");
        rk_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        watch_no_valid("no_valid_after_emit_abort");
        do_run(rand_key(), 1'b1, 1'b0);
    endtask

    task automatic test_start_noise();
        logic [79:0] k;
        k = rand_key();
        do_run(k, 1'b1, 1'b1);
        n_tests++;
        if (obs_rk[0] !== k[79:16]) begin
            n_fail++;
            $display("FAIL noise_final_key: rk=%h, expected %h", obs_rk[0], k[79:16]);
        end
        repeat (3) @(negedge clk);
        check_idle_outputs("no_restart_from_final_start");
    endtask

    task automatic test_back_to_back();
        do_run({80{1'b1}}, 1'b0, 1'b0);
        do_run(80'h0123_4567_89AB_CDEF_0123, 1'b0, 1'b0);
        n_tests++;
        if (obs_rk[0] !== 64'h0123_4567_89AB_CDEF) begin
            n_fail++;
            $display("FAIL b2b_final_key: rk=%h, expected 0123456789abcdef", obs_rk[0]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_zero_key();
        test_random_keys();
        test_stall();
        test_reset_abort();
        test_start_noise();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inv_ksa.md
INV_KSA -- requirements
Module: inv_ksa

Interface
REQ-001: Parameter KEY_SIZE, default 80; width of the key register, which is the PRESENT-80 key state.
REQ-002: Parameter NUM_ROUNDS, default 31; number of key-update steps, giving NUM_ROUNDS+1 round keys.
REQ-003: The block SHALL have one clock and an asynchronous, active-low reset: clk in 1 is the clock; rst in 1 is the async active-low reset.
REQ-004: start  in  1  request; key is captured when start is sampled high in IDLE.
REQ-005: key  in  KEY_SIZE  master key (K_1).
REQ-006: busy  out  1  high in every state except IDLE.
REQ-007: rk_valid  out  1  a round key is presented on rk.
REQ-008: rk_ready  in  1  consumer accepts rk.
REQ-009: rk  out  64  round key, equal to state bits [79:16].
REQ-010: rk_idx  out  5  round number minus 1 (31 down to 0).
REQ-011: rk_last  out  1  high together with rk_valid when rk_idx==0.

Function
REQ-012: Forward step with counter i SHALL be: R = state rotated left by 61; R[79:76] = S(R[79:76]); R[19:15] ^= i[4:0].
REQ-013: Inverse step with counter i SHALL be: R[19:15] ^= i; R[79:76] = InvS(R[79:76]); then rotate right by 61. It SHALL be the exact inverse of REQ-012.
REQ-014: The FSM SHALL have states IDLE, FWD and EMIT.
REQ-015: IDLE: when start=1, the block SHALL load state=key and ctr=1, and go to FWD; start SHALL be ignored in every other state.
REQ-016: FWD: each cycle the block SHALL apply the forward step with counter ctr, then ctr++; after the step with ctr=31 it SHALL go to EMIT with rk_idx=31.
REQ-017: EMIT: rk_valid=1, rk=state[79:16] (K_{rk_idx+1}).
REQ-018: On a handshake (rk_valid & rk_ready) with rk_idx>0, the block SHALL apply the inverse step with counter rk_idx, then rk_idx--.
REQ-019: On a handshake with rk_idx==0, the block SHALL return to IDLE and drop rk_valid in the next cycle.
REQ-020: rk_valid SHALL rise exactly 32 clock edges after the edge that samples start (1 load edge plus 31 FWD edges).
REQ-021: With rk_ready held high, the block SHALL deliver one key per cycle, with exactly 32 handshakes per run.
REQ-022: While rk_valid=1 and rk_ready=0, rk, rk_idx and rk_last SHALL stay stable for any number of cycles.
REQ-023: Changes on key after capture SHALL have no effect on the run in progress.
REQ-024: In IDLE, rk, rk_idx, rk_valid and rk_last SHALL be 0.
REQ-025: start asserted in the same cycle as the final handshake SHALL be ignored; a new run SHALL need start to be sampled in IDLE.

Reset
REQ-026: When rst=0, the block SHALL asynchronously go to IDLE and clear the state register, ctr, rk_idx, rk_valid, rk_last and busy to 0.
REQ-027: Reset during FWD or EMIT SHALL abort the run; no further rk_valid SHALL occur until a new start.
REQ-028: After rst is released, the first start SHALL behave exactly as in REQ-015.

Structure
REQ-029: A shared package SHALL hold KEY_SIZE, NUM_ROUNDS, the PRESENT S-box table, the inverse S-box table and the FSM state enum.
REQ-030: The PRESENT S-box table is C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2; the inverse S-box table is 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
REQ-031: The block SHALL contain one sub-module, inv_sbox (4-bit combinational), used by the inverse step.
REQ-032: The forward S-box SHALL reuse the existing SBox module.

Verification
REQ-033: key=0, rk_ready=1 -> 32 handshakes with rk_idx 31..0; rk_idx=1 gives rk=0xC000000000000000; rk_idx=0 gives rk=0x0000000000000000 with rk_last=1.
REQ-034: Random keys -> every rk equals a reference forward-schedule model, in reverse order; the final rk equals key[79:16].
REQ-035: Toggle rk_ready randomly -> rk and rk_idx stable while stalled; no key lost or duplicated; 32 handshakes total.
REQ-036: Assert rst during FWD at cycle 10 and during EMIT at rk_idx=17 -> outputs 0 immediately; a clean run follows the next start.
REQ-037: start pulses during FWD and EMIT, and key changes during a run -> no effect; output matches the key captured at the original start.
REQ-038: Two runs back to back (key=0xFFFF...FF, then 0x0123456789ABCDEF0123) -> both sequences correct; busy=0 for at least one cycle between runs.
